alarm_ctrl_multi: RTL and testbench

Parametrised multi-channel successor to the single-alarm snooze/stop control circuit. Holds N_ALARMS independent alarm set-points (minute, hour, day mask, enable). Each channel runs its own ring/snooze/stop state machine, with per-channel snooze-limit and auto-stop timers driven by the 1 Hz Tick strobe. It sits between the time-of-day counters and the ringer/display logic and replaces the fixed 16-bit snooze and stop counters.

---
 rtl/alarm_ctrl_multi_if.sv | 36 +++
 rtl/alarm_ctrl_multi.sv | 176 +++++++++++++++++
 tb/tb_alarm_ctrl_multi.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_ctrl_multi_if.sv
// Bundle between the time-of-day/config/button sources and the multi-channel
// alarm controller. The outputs drive the ringer and display logic.
interface alarm_ctrl_multi_if #(
  parameter int N_ALARMS = 4,
  parameter int SEL_W    = 2
);
  logic                Tick;
  logic [5:0]          CurMin;
  logic [4:0]          CurHour;
  logic [2:0]          CurDay;
  logic                Wr;
  logic [SEL_W-1:0]    WrSel;
  logic [5:0]          WrMin;
  logic [4:0]          WrHour;
  logic [6:0]          WrDayMask;
  logic                WrEn;
  logic                EN_SNZ;
  logic                EN_STOP;
  logic                Ring;
  logic [SEL_W-1:0]    RingId;
  logic [N_ALARMS-1:0] Active;
  logic [N_ALARMS-1:0] Snoozed;
  logic [N_ALARMS-1:0] Missed;

  modport master (
    output Tick, CurMin, CurHour, CurDay, Wr, WrSel, WrMin, WrHour, WrDayMask,
           WrEn, EN_SNZ, EN_STOP,
    input  Ring, RingId, Active, Snoozed, Missed
  );

  modport slave (
    input  Tick, CurMin, CurHour, CurDay, Wr, WrSel, WrMin, WrHour, WrDayMask,
           WrEn, EN_SNZ, EN_STOP,
    output Ring, RingId, Active, Snoozed, Missed
  );
endinterface

// File: rtl/alarm_ctrl_multi.sv
// Multi-channel alarm controller: per-channel set-point match, ring/snooze/stop
// FSM with Tick-driven snooze and auto-stop timers, merged into Ring/RingId.
module alarm_chan #(
  parameter int TICK_W     = 16,
  parameter int SNZ_TICKS  = 600,
  parameter int RING_TICKS = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [5:0] cur_min,
  input  logic [4:0] cur_hour,
  input  logic [2:0] cur_day,
  input  logic       wr,
  input  logic [5:0] wr_min,
  input  logic [4:0] wr_hour,
  input  logic [6:0] wr_mask,
  input  logic       wr_en,
  input  logic       snz,
  input  logic       stop,
  output logic       ringing,
  output logic       active,
  output logic       snoozed,
  output logic       missed
);
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

  localparam logic [TICK_W-1:0] RING_T = TICK_W'(RING_TICKS);
  localparam logic [TICK_W-1:0] SNZ_T  = TICK_W'(SNZ_TICKS);
  localparam logic [2:0]        MAX_C  = 3'(MAX_SNOOZE);

  state_t            state_q, state_d;
  logic [TICK_W-1:0] timer_q, timer_d, timer_inc;
  logic [2:0]        cnt_q, cnt_d;
  logic              missed_q, missed_d;
  logic              match, match_q, trig;
  logic [5:0]        min_q;
  logic [4:0]        hour_q;
  logic [6:0]        mask_q;
  logic              en_q;
  logic [7:0]        mask_ext;

  // Pad the mask so an out-of-range weekday 7 simply never matches
  assign mask_ext  = {1'b0, mask_q};
  assign match     = en_q && (min_q == cur_min) && (hour_q == cur_hour) && mask_ext[cur_day];
  assign trig      = match && !match_q;
  assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    missed_d = missed_q;
    if (wr) begin
      state_d  = IDLE;
      timer_d  = '0;
      cnt_d    = '0;
      missed_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (trig) begin
          state_d = RINGING;
          timer_d = '0;
          cnt_d   = '0;
        end
        RINGING: begin
          if (stop) begin
            state_d = IDLE;
          end else if (snz && (cnt_q < MAX_C)) begin
            state_d = SNOOZED;
            timer_d = '0;
            cnt_d   = cnt_q + 1'b1;
          end else if (tick) begin
            timer_d = timer_inc;
            if (timer_inc == RING_T) begin
              state_d  = IDLE;
              timer_d  = '0;
              missed_d = 1'b1;
            end
          end
        end
        SNOOZED: begin
          if (stop) begin
            state_d = IDLE;
          end else if (tick) begin
            timer_d = timer_inc;
            if (timer_inc == SNZ_T) begin
              state_d = RINGING;
              timer_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      cnt_q    <= '0;
      missed_q <= 1'b0;
      match_q  <= 1'b0;
      min_q    <= '0;
      hour_q   <= '0;
      mask_q   <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      missed_q <= missed_d;
      // Clearing history on write lets a set-point equal to "now" fire next cycle
      match_q  <= wr ? 1'b0 : match;
      if (wr) begin
        min_q  <= wr_min;
        hour_q <= wr_hour;
        mask_q <= wr_mask;
        en_q   <= wr_en;
      end
    end
  end

  assign ringing = (state_q == RINGING);
  assign snoozed = (state_q == SNOOZED);
  assign active  = en_q;
  assign missed  = missed_q;
endmodule

module alarm_ctrl_multi #(
  parameter int N_ALARMS   = 4,
  parameter int SEL_W      = 2,
  parameter int TICK_W     = 16,
  parameter int SNZ_TICKS  = 600,
  parameter int RING_TICKS = 300,
  parameter int MAX_SNOOZE = 3
) (
  input logic          Clk,
  input logic          Clr_n,
  alarm_ctrl_multi_if.slave bus
);
  logic [N_ALARMS-1:0] wr_hit, ringing, active, snoozed, missed;
  logic [SEL_W-1:0]    ring_id;

  for (genvar i = 0; i < N_ALARMS; i++) begin : g_chan
    // Selects beyond the last channel match no wr_hit bit and are dropped
    assign wr_hit[i] = bus.Wr && (bus.WrSel == SEL_W'(i));

    alarm_chan #(
      .TICK_W(TICK_W), .SNZ_TICKS(SNZ_TICKS),
      .RING_TICKS(RING_TICKS), .MAX_SNOOZE(MAX_SNOOZE)
    ) u_chan (
      .clk(Clk), .rst_n(Clr_n), .tick(bus.Tick),
      .cur_min(bus.CurMin), .cur_hour(bus.CurHour), .cur_day(bus.CurDay),
      .wr(wr_hit[i]), .wr_min(bus.WrMin), .wr_hour(bus.WrHour),
      .wr_mask(bus.WrDayMask), .wr_en(bus.WrEn),
      .snz(bus.EN_SNZ), .stop(bus.EN_STOP),
      .ringing(ringing[i]), .active(active[i]),
      .snoozed(snoozed[i]), .missed(missed[i])
    );
  end

  always_comb begin
    ring_id = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--)
      if (ringing[i]) ring_id = SEL_W'(i);
  end

  assign bus.Ring    = |ringing;
  assign bus.RingId  = ring_id;
  assign bus.Active  = active;
  assign bus.Snoozed = snoozed;
  assign bus.Missed  = missed;
endmodule

// File: tb/tb_alarm_ctrl_multi.sv
// Directed walk through the alarm scenarios, then random traffic, all checked
// against a countdown-based reference model of every channel.
module tb_alarm_ctrl_multi;
  localparam int N    = 4;
  localparam int SW   = 3;
  localparam int SNZ  = 5;
  localparam int RING = 8;
  localparam int MAXS = 2;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  alarm_ctrl_multi_if #(.N_ALARMS(N), .SEL_W(SW)) bus ();

  alarm_ctrl_multi #(
    .N_ALARMS(N), .SEL_W(SW), .TICK_W(16),
    .SNZ_TICKS(SNZ), .RING_TICKS(RING), .MAX_SNOOZE(MAXS)
  ) dut (.Clk(clk), .Clr_n(clr_n), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // model: each channel is ringing, snoozing or neither, with ticks left
  // before its current phase expires and snoozes still available
  bit       m_en[N], m_prev[N], m_ring[N], m_snz[N], m_miss[N];
  int       m_min[N], m_hour[N], m_left[N], m_snz_left[N];
  bit [6:0] m_mask[N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_prev[i] = 0; m_ring[i] = 0; m_snz[i] = 0; m_miss[i] = 0;
      m_min[i] = 0; m_hour[i] = 0; m_left[i] = 0; m_snz_left[i] = 0; m_mask[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      bit match, trig;
      match = m_en[i] && m_min[i] == int'(bus.CurMin) && m_hour[i] == int'(bus.CurHour)
              && m_mask[i][bus.CurDay];
      if (bus.Wr && int'(bus.WrSel) == i) begin
        m_min[i] = bus.WrMin; m_hour[i] = bus.WrHour; m_mask[i] = bus.WrDayMask;
        m_en[i] = bus.WrEn; m_ring[i] = 0; m_snz[i] = 0; m_miss[i] = 0; m_prev[i] = 0;
        continue;
      end
      trig = match && !m_prev[i];
      m_prev[i] = match;
      if (m_ring[i]) begin
        if (bus.EN_STOP) m_ring[i] = 0;
        else if (bus.EN_SNZ && m_snz_left[i] > 0) begin
          m_ring[i] = 0; m_snz[i] = 1; m_left[i] = SNZ; m_snz_left[i]--;
        end else if (bus.Tick) begin
          m_left[i]--;
          if (m_left[i] == 0) begin m_ring[i] = 0; m_miss[i] = 1; end
        end
      end else if (m_snz[i]) begin
        if (bus.EN_STOP) m_snz[i] = 0;
        else if (bus.Tick) begin
          m_left[i]--;
          if (m_left[i] == 0) begin m_snz[i] = 0; m_ring[i] = 1; m_left[i] = RING; end
        end
      end else if (trig) begin
        m_ring[i] = 1; m_left[i] = RING; m_snz_left[i] = MAXS;
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] act, snz, miss;
    logic         ring;
    logic [SW-1:0] id;
    ring = 0; id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      act[i] = m_en[i]; snz[i] = m_snz[i]; miss[i] = m_miss[i];
      if (m_ring[i]) begin ring = 1; id = SW'(i); end
    end
    chk("Ring", 32'(bus.Ring), 32'(ring));
    chk("RingId", 32'(bus.RingId), 32'(id));
    chk("Active", 32'(bus.Active), 32'(act));
    chk("Snoozed", 32'(bus.Snoozed), 32'(snz));
    chk("Missed", 32'(bus.Missed), 32'(miss));
  endtask

  // inputs are held from one negedge to the next; pulses drop after one cycle
  task automatic cycle();
    @(posedge clk);
    if (clr_n) model_step();
    @(negedge clk);
    check_all();
    bus.Wr = 0; bus.Tick = 0; bus.EN_SNZ = 0; bus.EN_STOP = 0;
  endtask

  task automatic set_time(input int h, input int m, input int d);
    bus.CurHour = 5'(h); bus.CurMin = 6'(m); bus.CurDay = 3'(d);
  endtask

  task automatic wr_cfg(input int sel, input int h, input int m, input int mask, input bit en);
    bus.Wr = 1; bus.WrSel = SW'(sel); bus.WrHour = 5'(h); bus.WrMin = 6'(m);
    bus.WrDayMask = 7'(mask); bus.WrEn = en;
    cycle();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin bus.Tick = 1; cycle(); end
  endtask

  initial begin
    bus.Tick = 0; bus.Wr = 0; bus.WrSel = '0; bus.WrMin = '0; bus.WrHour = '0;
    bus.WrDayMask = '0; bus.WrEn = 0; bus.EN_SNZ = 0; bus.EN_STOP = 0;
    set_time(0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    clr_n = 1;

    // first ring, one cycle after the matching time appears
    set_time(7, 29, 0);
    wr_cfg(1, 7, 30, 7'h7F, 1);
    cycle();
    set_time(7, 30, 0);
    cycle();
    chk("s1_ring", 32'(bus.Ring), 1);
    chk("s1_id", 32'(bus.RingId), 1);
    repeat (3) cycle();
    chk("s1_hold", 32'(bus.Ring), 1);

    // two snoozes allowed, third ignored
    bus.EN_SNZ = 1; cycle();
    chk("s2_snz", 32'(bus.Snoozed[1]), 1);
    chk("s2_quiet", 32'(bus.Ring), 0);
    ticks(SNZ - 1);
    chk("s2_early", 32'(bus.Ring), 0);
    ticks(1);
    chk("s2_rering", 32'(bus.Ring), 1);
    bus.EN_SNZ = 1; cycle();
    ticks(SNZ);
    bus.EN_SNZ = 1; cycle();
    chk("s2_limit", 32'(bus.Ring), 1);

    // auto-stop after RING ticks, rewrite clears Missed
    ticks(RING - 1);
    chk("s3_pre", 32'(bus.Ring), 1);
    ticks(1);
    chk("s3_tmo", 32'(bus.Ring), 0);
    chk("s3_miss", 32'(bus.Missed[1]), 1);
    wr_cfg(1, 7, 30, 7'h7F, 1);
    chk("s3_clr", 32'(bus.Missed[1]), 0);
    cycle();
    chk("s3_retrig", 32'(bus.Ring), 1);

    // stop inside the matching minute does not re-ring
    bus.EN_STOP = 1; cycle();
    repeat (5) begin bus.Tick = 1; cycle(); end
    chk("s4_noring", 32'(bus.Ring), 0);
    set_time(7, 31, 1); cycle();
    set_time(7, 30, 1); cycle();
    chk("s4_nextday", 32'(bus.Ring), 1);
    bus.EN_STOP = 1; cycle();

    // two channels at once; snooze+stop together is a stop
    wr_cfg(0, 6, 0, 7'h7F, 1);
    wr_cfg(2, 6, 0, 7'h7F, 1);
    set_time(5, 59, 2); cycle();
    set_time(6, 0, 2); cycle();
    chk("s5_ring", 32'(bus.Ring), 1);
    chk("s5_id", 32'(bus.RingId), 0);
    bus.EN_SNZ = 1; bus.EN_STOP = 1; cycle();
    chk("s5_stop", 32'(bus.Ring), 0);
    chk("s5_nosnz", 32'(bus.Snoozed), 0);

    // day mask, out-of-range write
    wr_cfg(3, 8, 0, 7'h02, 1);
    set_time(7, 59, 3); cycle();
    set_time(8, 0, 3); cycle();
    chk("s6_mask", 32'(bus.Ring), 0);
    wr_cfg(5, 8, 0, 7'h7F, 1);
    cycle();
    chk("s6_wrsel", 32'(bus.Ring), 0);
    chk("s6_active", 32'(bus.Active), 32'hF);

    // asynchronous reset mid-snooze
    wr_cfg(0, 9, 0, 7'h7F, 1);
    set_time(9, 0, 3); cycle();
    bus.EN_SNZ = 1; cycle();
    ticks(2);
    chk("s7_snz", 32'(bus.Snoozed[0]), 1);
    #2 clr_n = 0;
    #1 model_reset();
    chk("s7_ring", 32'(bus.Ring), 0);
    chk("s7_act", 32'(bus.Active), 0);
    chk("s7_snzd", 32'(bus.Snoozed), 0);
    check_all();
    @(negedge clk);
    clr_n = 1;

    // random traffic in a narrow time window so matches are frequent
    set_time(0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0)
        set_time(0, $urandom_range(0, 2), $urandom_range(0, 6));
      if ($urandom_range(0, 11) == 0) begin
        bus.Wr = 1; bus.WrSel = SW'($urandom_range(0, 7));
        bus.WrHour = 0; bus.WrMin = 6'($urandom_range(0, 2));
        bus.WrDayMask = 7'($urandom_range(0, 127)); bus.WrEn = ($urandom_range(0, 3) != 0);
      end
      bus.Tick    = ($urandom_range(0, 1) == 0);
      bus.EN_SNZ  = ($urandom_range(0, 9) == 0);
      bus.EN_STOP = ($urandom_range(0, 24) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
